mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Downstream stage of the bit-serial multiplier in the bit-serial MAC datapath.
- Consumes each finished product, qualified by the multiplier's one-cycle done pulse, and sums NUM_TERMS consecutive products into one dot-product result.
- Emits the registered sum with a one-cycle valid pulse and a sticky saturation flag, then rearms for the next batch.

Parameters:
- PRODUCT_WIDTH, 32, width of incoming unsigned product (matches multiplier product width)
- ACC_WIDTH, 40, accumulator/result width; must be >= PRODUCT_WIDTH
- NUM_TERMS, 8, products per batch; must be >= 1

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous batch abort/flush
- product_in  input  PRODUCT_WIDTH  unsigned product from multiplier
- product_valid  input  1  one-cycle pulse; product_in valid this cycle (multiplier done)
- acc_out  output  ACC_WIDTH  registered batch sum
- acc_valid  output  1  one-cycle pulse; acc_out/acc_overflow updated
- acc_overflow  output  1  registered with acc_out; 1 if batch saturated
- busy  output  1  1 while a batch is partially accumulated (state ACCUM)
- term_count  output  $clog2(NUM_TERMS+1)  products accepted in current batch

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE; internal acc=0, ovf=0.
- Reset values of all outputs: acc_out=0, acc_valid=0, acc_overflow=0, busy=0, term_count=0.
- Reset mid-batch discards the partial sum immediately, with no acc_valid.
- States:
  - IDLE: no partial sum.
  - ACCUM: 1..NUM_TERMS-1 terms held.
  - EMIT: one cycle, acc_valid=1.
- Arithmetic:
  - product_in is zero-extended to ACC_WIDTH+1 and added to acc.
  - If bit ACC_WIDTH of the sum is 1, acc saturates to all-ones and ovf is set. ovf is sticky for the rest of the batch.
  - The first term of a batch loads acc = product_in, with no add to the old value.
- Transitions, evaluated on each rising edge:
  - clear=1: highest priority below rst.
    - Go to IDLE; acc=0, ovf=0, term_count=0, acc_valid=0.
    - acc_out and acc_overflow hold their values.
    - A product_valid in the same cycle is dropped.
  - IDLE or EMIT with product_valid=1:
    - Load the first term; term_count=1.
    - If NUM_TERMS==1, go to EMIT. Otherwise go to ACCUM.
  - IDLE with product_valid=0: stay in IDLE.
  - EMIT with product_valid=0: go to IDLE; term_count=0.
  - ACCUM with product_valid=1 and term_count < NUM_TERMS-1: add the term, term_count+1.
  - ACCUM with product_valid=1 and term_count == NUM_TERMS-1 (final term):
    - acc_out <= saturated(acc+product_in).
    - acc_overflow <= ovf OR carry of this add.
    - acc_valid <= 1; go to EMIT.
    - Internal acc and ovf are cleared; term_count <= NUM_TERMS.
  - ACCUM with product_valid=0: hold all state.
- Latency: acc_valid asserts in the cycle immediately after the edge that samples the final product_valid. It is high for exactly one cycle unless the next batch's final term also lands, which is only possible when NUM_TERMS==1.
- Back-to-back: a product_valid in the EMIT cycle is the first term of the next batch and is never lost.
  - With NUM_TERMS==1 and continuous valid, acc_valid stays high and acc_out updates every cycle.
- Outputs:
  - busy = (state==ACCUM).
  - acc_valid is low in IDLE and ACCUM.
  - acc_out and acc_overflow hold between pulses.
- There is no backpressure. The consumer must sample on acc_valid.

Test Plan:
- Basic sum (NUM_TERMS=4, ACC_WIDTH=40): products 15, 7, 100, 1 with gaps of 18 cycles.
  - Required: acc_valid pulses once, 1 cycle after the 4th valid; acc_out=123; acc_overflow=0; busy high from after the 1st valid until the 4th valid; term_count steps 1,2,3,4 then returns to 0.
- Saturation (PRODUCT_WIDTH=32, ACC_WIDTH=32, NUM_TERMS=2): products 0xFFFFFFFF, then 2.
  - Required: acc_out=0xFFFFFFFF, acc_overflow=1. The next batch of 1 and 1 gives acc_out=2, acc_overflow=0.
- Back-to-back batches (NUM_TERMS=2): valids on consecutive cycles with values 5, 6, 7, 8.
  - Required: acc_valid in cycle 3 with acc_out=11; the 7 taken in the EMIT cycle; acc_valid in cycle 5 with acc_out=15.
- Clear mid-batch (NUM_TERMS=4): products 10 and 20, then clear together with valid 99, then products 1, 2, 3, 4.
  - Required: 99 is dropped; no acc_valid for the aborted batch; the next acc_valid gives acc_out=10; the previous acc_out is held until then.
- Async reset mid-batch: assert rst between edges after 2 of 4 terms.
  - Required: all outputs are 0 immediately, without waiting for an edge. After release, 4 products of 1 give acc_out=4.
- NUM_TERMS=1: continuous valids 3, 4, 5.
  - Required: acc_valid high for 3 consecutive cycles with acc_out 3, 4, 5; busy never asserts.

Source files
------------

// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Sums NUM_TERMS consecutive unsigned products from the bit-serial
//   multiplier into one saturating dot-product result.
//
// Ports
//   clk           : rising-edge clock
//   rst           : asynchronous, active-high reset
//   clear         : synchronous batch abort (drops any product in the same cycle)
//   product_in    : unsigned product, qualified by product_valid
//   product_valid : one-cycle pulse, product_in is valid
//   acc_out       : registered batch sum (holds between pulses)
//   acc_valid     : one-cycle pulse, acc_out/acc_overflow just updated
//   acc_overflow  : batch saturated, registered alongside acc_out
//   busy          : partial batch held (state ACCUM)
//   term_count    : products accepted in the current batch
//
// Handshake: there is no backpressure. A product is taken on every rising
// edge where product_valid=1 and clear=0; the consumer must capture acc_out
// in the cycle acc_valid=1.
module mac_accumulator #(
    parameter int PRODUCT_WIDTH = 32,
    parameter int ACC_WIDTH     = 40,
    parameter int NUM_TERMS     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic [PRODUCT_WIDTH-1:0]       product_in,
    input  logic                           product_valid,
    output logic [ACC_WIDTH-1:0]           acc_out,
    output logic                           acc_valid,
    output logic                           acc_overflow,
    output logic                           busy,
    output logic [$clog2(NUM_TERMS+1)-1:0] term_count
);

    localparam int CW = $clog2(NUM_TERMS + 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_TERMS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_TERMS);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;

    logic [ACC_WIDTH-1:0] product_ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic [ACC_WIDTH-1:0] sat_sum;

    logic take;
    logic load_first;
    logic add_term;
    logic finish;

    // One extra bit catches the carry; any carry saturates the result.
    assign product_ext = ACC_WIDTH'(product_in);
    assign sum         = {1'b0, acc} + {1'b0, product_ext};
    assign carry       = sum[ACC_WIDTH];
    assign sat_sum     = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];

    // clear outranks a product arriving in the same cycle.
    assign take       = product_valid && !clear;
    // The EMIT cycle accepts the first term of the next batch, same as IDLE.
    assign load_first = take && (state != ACCUM);
    assign add_term   = take && (state == ACCUM);
    // With a single-term batch the first term is also the final one.
    assign finish     = (load_first && (NUM_TERMS == 1)) ||
                        (add_term && (term_count == LAST_IDX));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, EMIT: begin
                    if (load_first) begin
                        state_next = finish ? EMIT : ACCUM;
                    end else begin
                        state_next = IDLE;
                    end
                end
                ACCUM: begin
                    if (finish) begin
                        state_next = EMIT;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        busy      = (state == ACCUM);
        acc_valid = (state == EMIT);
    end

    // Accumulator datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            ovf          <= 1'b0;
            term_count   <= '0;
            acc_out      <= '0;
            acc_overflow <= 1'b0;
        end else if (clear) begin
            // Result registers keep the last completed batch.
            acc        <= '0;
            ovf        <= 1'b0;
            term_count <= '0;
        end else if (finish) begin
            acc_out      <= load_first ? product_ext : sat_sum;
            acc_overflow <= load_first ? 1'b0 : (ovf | carry);
            acc          <= '0;
            ovf          <= 1'b0;
            term_count   <= FULL_CNT;
        end else if (load_first) begin
            // First term replaces the old value; no add, so no saturation.
            acc        <= product_ext;
            ovf        <= 1'b0;
            term_count <= ONE_CNT;
        end else if (add_term) begin
            acc        <= sat_sum;
            ovf        <= ovf | carry;
            term_count <= term_count + ONE_CNT;
        end else if (state == EMIT) begin
            term_count <= '0;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator with three instances:
//   unit 0: ACC_WIDTH=40, NUM_TERMS=4
//   unit 1: ACC_WIDTH=32, NUM_TERMS=2 (saturation, back-to-back)
//   unit 2: ACC_WIDTH=40, NUM_TERMS=1
// Expected results are the plain sum of each batch, clipped to the
// accumulator range, tagged with the unit and the cycle they must appear.
module tb_mac_accumulator;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Stimulus signals and DUTs
    // ------------------------------------------------------------------
    logic        pv  [3];
    logic        clr [3];
    logic [31:0] pin [3];

    logic [39:0] aout_a;
    logic        av_a, aovf_a, busy_a;
    logic [2:0]  tc_a;
    logic [31:0] aout_b;
    logic        av_b, aovf_b, busy_b;
    logic [1:0]  tc_b;
    logic [39:0] aout_c;
    logic        av_c, aovf_c, busy_c;
    logic [0:0]  tc_c;

    logic [39:0] aout [3];
    logic        av   [3];
    logic        aovf [3];
    logic        bsy  [3];
    logic [2:0]  tc   [3];

    always_comb begin
        aout[0] = aout_a;        av[0] = av_a; aovf[0] = aovf_a; bsy[0] = busy_a; tc[0] = tc_a;
        aout[1] = 40'(aout_b);   av[1] = av_b; aovf[1] = aovf_b; bsy[1] = busy_b; tc[1] = 3'(tc_b);
        aout[2] = aout_c;        av[2] = av_c; aovf[2] = aovf_c; bsy[2] = busy_c; tc[2] = 3'(tc_c);
    end

    mac_accumulator #(.PRODUCT_WIDTH(32), .ACC_WIDTH(40), .NUM_TERMS(4)) dut_a (
        .clk(clk), .rst(rst), .clear(clr[0]), .product_in(pin[0]), .product_valid(pv[0]),
        .acc_out(aout_a), .acc_valid(av_a), .acc_overflow(aovf_a), .busy(busy_a), .term_count(tc_a)
    );

    mac_accumulator #(.PRODUCT_WIDTH(32), .ACC_WIDTH(32), .NUM_TERMS(2)) dut_b (
        .clk(clk), .rst(rst), .clear(clr[1]), .product_in(pin[1]), .product_valid(pv[1]),
        .acc_out(aout_b), .acc_valid(av_b), .acc_overflow(aovf_b), .busy(busy_b), .term_count(tc_b)
    );

    mac_accumulator #(.PRODUCT_WIDTH(32), .ACC_WIDTH(40), .NUM_TERMS(1)) dut_c (
        .clk(clk), .rst(rst), .clear(clr[2]), .product_in(pin[2]), .product_valid(pv[2]),
        .acc_out(aout_c), .acc_valid(av_c), .acc_overflow(aovf_c), .busy(busy_c), .term_count(tc_c)
    );

    // ------------------------------------------------------------------
    // Scoreboard: {unit[1:0], cycle[15:0], overflow, sum[39:0]}
    // ------------------------------------------------------------------
    logic [58:0] exp_q[$];
    logic [63:0] tot [3];
    int          cnt [3];
    int          checks;
    int          failures;

    function automatic int nterms(input int d);
        case (d)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int accw(input int d);
        return (d == 1) ? 32 : 40;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            tot[d] = '0;
            cnt[d] = 0;
        end
    endtask

    // Called in the cycle the product is driven; the result is due one edge later.
    task automatic model_add(input int d, input logic [31:0] p);
        logic [63:0] maxv;
        logic [63:0] res;
        logic        o;
        tot[d] = tot[d] + 64'(p);
        cnt[d]++;
        if (cnt[d] == nterms(d)) begin
            maxv = (64'd1 << accw(d)) - 64'd1;
            o    = (tot[d] > maxv);
            res  = o ? maxv : tot[d];
            exp_q.push_back({2'(d), 16'(cyc + 1), o, res[39:0]});
            tot[d] = '0;
            cnt[d] = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int d, input logic [31:0] p, input logic c);
        pv[d]  = 1'b1;
        pin[d] = p;
        clr[d] = c;
        if (c) begin
            tot[d] = '0;
            cnt[d] = 0;
        end else begin
            model_add(d, p);
        end
        tick();
        pv[d]  = 1'b0;
        clr[d] = 1'b0;
        pin[d] = $urandom;
    endtask

    task automatic do_clear(input int d);
        clr[d] = 1'b1;
        tot[d] = '0;
        cnt[d] = 0;
        tick();
        clr[d] = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (av[d]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_acc_valid unit=%0d cycle=%0d actual=1 required=0", d, cyc);
                    end else begin
                        check($sformatf("acc_result unit%0d", d),
                              64'({2'(d), 16'(cyc), aovf[d], aout[d]}), 64'(exp_q.pop_front()));
                    end
                end
            end
            check("busy_n1", 64'(bsy[2]), 64'd0);
        end
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst      = 1'b1;
        for (int d = 0; d < 3; d++) begin
            pv[d]  = 1'b0;
            clr[d] = 1'b0;
            pin[d] = '0;
        end
        model_reset();
        idle(3);

        // Reset values
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_acc_out%0d", d), 64'(aout[d]), 64'd0);
            check($sformatf("rst_flags%0d", d),
                  64'({av[d], aovf[d], bsy[d], tc[d]}), 64'd0);
        end
        rst = 1'b0;
        idle(2);

        // Basic sum, unit 0: 15, 7, 100, 1 with 18-cycle gaps -> 123
        check("basic_busy_pre", 64'(bsy[0]), 64'd0);
        send(0, 32'd15, 1'b0);
        check("basic_tc1", 64'({bsy[0], tc[0]}), 64'({1'b1, 3'd1}));
        idle(18);
        check("basic_hold", 64'({bsy[0], tc[0]}), 64'({1'b1, 3'd1}));
        send(0, 32'd7, 1'b0);
        check("basic_tc2", 64'({bsy[0], tc[0]}), 64'({1'b1, 3'd2}));
        idle(18);
        send(0, 32'd100, 1'b0);
        check("basic_tc3", 64'({bsy[0], tc[0]}), 64'({1'b1, 3'd3}));
        idle(18);
        send(0, 32'd1, 1'b0);
        check("basic_tc4", 64'({bsy[0], tc[0]}), 64'({1'b0, 3'd4}));
        tick();
        check("basic_tc0", 64'({av[0], bsy[0], tc[0]}), 64'd0);
        idle(3);

        // Saturation, unit 1
        send(1, 32'hFFFF_FFFF, 1'b0);
        send(1, 32'd2, 1'b0);
        idle(3);
        send(1, 32'd1, 1'b0);
        send(1, 32'd1, 1'b0);
        idle(3);

        // Back-to-back, unit 1: 5,6 -> 11; 7,8 -> 15
        send(1, 32'd5, 1'b0);
        send(1, 32'd6, 1'b0);
        check("b2b_emit_state", 64'({av[1], tc[1]}), 64'({1'b1, 3'd2}));
        send(1, 32'd7, 1'b0);
        check("b2b_first_in_emit", 64'({bsy[1], tc[1]}), 64'({1'b1, 3'd1}));
        send(1, 32'd8, 1'b0);
        idle(3);

        // Clear mid-batch, unit 0: 99 dropped, then 1+2+3+4 = 10
        send(0, 32'd10, 1'b0);
        send(0, 32'd20, 1'b0);
        send(0, 32'd99, 1'b1);
        check("clear_hold_out", 64'(aout[0]), 64'd123);
        check("clear_state", 64'({av[0], bsy[0], tc[0]}), 64'd0);
        send(0, 32'd1, 1'b0);
        send(0, 32'd2, 1'b0);
        send(0, 32'd3, 1'b0);
        check("clear_hold_out2", 64'(aout[0]), 64'd123);
        send(0, 32'd4, 1'b0);
        idle(3);

        // Asynchronous reset between edges after 2 of 4 terms
        send(0, 32'd1, 1'b0);
        send(0, 32'd1, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_out", 64'(aout[0]), 64'd0);
        check("async_rst_flags", 64'({av[0], aovf[0], bsy[0], tc[0]}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send(0, 32'd1, 1'b0);
        idle(3);

        // Single-term batches, unit 2: continuous 3, 4, 5
        send(2, 32'd3, 1'b0);
        send(2, 32'd4, 1'b0);
        send(2, 32'd5, 1'b0);
        idle(3);

        // Randomized traffic on each unit, with occasional clears
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 60; i++) begin
                logic [31:0] p;
                p = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 1000));
                if ($urandom_range(0, 15) == 0) begin
                    send(d, p, 1'b1);
                end else if ($urandom_range(0, 15) == 0) begin
                    do_clear(d);
                end else begin
                    send(d, p, 1'b0);
                end
                idle($urandom_range(0, 3));
            end
            idle(3);
        end

        // Every expected result must have appeared within the drain window
        idle(10);
        check("pending_results", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
